// File: rtl/tree_node_walker.sv
// Walks one decision tree from a root address to a leaf, issuing one
// (feature, threshold) compare per internal node and returning the leaf class.
module tree_node_walker #(
  parameter int DATA_W    = 24,
  parameter int FIDX_W    = 8,
  parameter int ADDR_W    = 10,
  parameter int CLASS_W   = 8,
  parameter int CMP_LAT   = 2,
  parameter int MAX_DEPTH = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start_valid,
  output logic                                   start_ready,
  input  logic [ADDR_W-1:0]                      root_addr,
  output logic                                   node_rd_en,
  output logic [ADDR_W-1:0]                      node_addr,
  input  logic [1+FIDX_W+DATA_W+2*ADDR_W-1:0]    node_rd_data,
  output logic                                   feat_rd_en,
  output logic [FIDX_W-1:0]                      feat_addr,
  input  logic [DATA_W-1:0]                      feat_rd_data,
  output logic [DATA_W-1:0]                      cmp_din1,
  output logic [DATA_W-1:0]                      cmp_din2,
  input  logic [7:0]                             cmp_result,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [CLASS_W-1:0]                     out_class,
  output logic                                   out_err
);

  localparam int NODE_W  = 1 + FIDX_W + DATA_W + 2 * ADDR_W;
  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);
  localparam int CNT_W   = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE, NODE, NODE_DATA, FEAT_DATA, CMP, DECIDE, OUT
  } state_t;

  state_t              state_reg;
  logic [ADDR_W-1:0]   cur_addr_reg;
  logic [DEPTH_W-1:0]  depth_reg;
  logic [CNT_W-1:0]    cmp_cnt_reg;
  logic [DATA_W-1:0]   thr_reg;
  logic [ADDR_W-1:0]   left_reg;
  logic [ADDR_W-1:0]   right_reg;

  logic                nd_leaf;
  logic [FIDX_W-1:0]   nd_fidx;
  logic [DATA_W-1:0]   nd_thr;
  logic [ADDR_W-1:0]   nd_left;
  logic [ADDR_W-1:0]   nd_right;
  logic                depth_hit;
  logic                unused_cmp_bits;

  assign nd_leaf   = node_rd_data[NODE_W-1];
  assign nd_fidx   = node_rd_data[NODE_W-2 -: FIDX_W];
  assign nd_thr    = node_rd_data[2*ADDR_W +: DATA_W];
  assign nd_left   = node_rd_data[ADDR_W +: ADDR_W];
  assign nd_right  = node_rd_data[0 +: ADDR_W];
  assign depth_hit = (depth_reg == DEPTH_W'(MAX_DEPTH));

  // The feature read must issue in the same cycle the node word arrives,
  // otherwise the per-node cost grows by one cycle.
  assign feat_rd_en = (state_reg == NODE_DATA) && !nd_leaf && !depth_hit;
  assign feat_addr  = feat_rd_en ? nd_fidx : '0;
  assign node_addr  = cur_addr_reg;

  assign unused_cmp_bits = ^cmp_result[7:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      start_ready  <= 1'b1;
      cur_addr_reg <= '0;
      depth_reg    <= '0;
      cmp_cnt_reg  <= '0;
      thr_reg      <= '0;
      left_reg     <= '0;
      right_reg    <= '0;
      node_rd_en   <= 1'b0;
      cmp_din1     <= '0;
      cmp_din2     <= '0;
      out_valid    <= 1'b0;
      out_class    <= '0;
      out_err      <= 1'b0;
    end else begin
      node_rd_en <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_valid) begin
            cur_addr_reg <= root_addr;
            depth_reg    <= '0;
            node_rd_en   <= 1'b1;
            start_ready  <= 1'b0;
            state_reg    <= NODE;
          end
        end
        NODE: state_reg <= NODE_DATA;
        NODE_DATA: begin
          thr_reg   <= nd_thr;
          left_reg  <= nd_left;
          right_reg <= nd_right;
          if (nd_leaf) begin
            out_class <= nd_thr[CLASS_W-1:0];
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            state_reg <= OUT;
          end else if (depth_hit) begin
            out_class <= '0;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
            state_reg <= OUT;
          end else begin
            state_reg <= FEAT_DATA;
          end
        end
        FEAT_DATA: begin
          cmp_din1    <= feat_rd_data;
          cmp_din2    <= thr_reg;
          cmp_cnt_reg <= '0;
          state_reg   <= CMP;
        end
        CMP: begin
          if (cmp_cnt_reg == CNT_W'(CMP_LAT - 1)) begin
            state_reg <= DECIDE;
          end else begin
            cmp_cnt_reg <= cmp_cnt_reg + 1'b1;
          end
        end
        DECIDE: begin
          // Bit 0 set means feature <= threshold: take the left child.
          cur_addr_reg <= cmp_result[0] ? left_reg : right_reg;
          depth_reg    <= depth_reg + 1'b1;
          node_rd_en   <= 1'b1;
          state_reg    <= NODE;
        end
        OUT: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            start_ready <= 1'b1;
            state_reg   <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tree_node_walker.sv
// Bench for tree_node_walker: RAM and comparator models around the walker,
// with a plain tree-walk reference that predicts path, timing and result.
module tb_tree_node_walker;

  localparam int DATA_W = 24, FIDX_W = 8, ADDR_W = 10, CLASS_W = 8;
  localparam int CMP_LAT = 2, MAX_DEPTH = 16;
  localparam int NODE_W = 1 + FIDX_W + DATA_W + 2 * ADDR_W;
  localparam int NODE_CYC = 4 + CMP_LAT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_valid = 1'b0;
  logic start_ready;
  logic [ADDR_W-1:0] root_addr = '0;
  logic node_rd_en;
  logic [ADDR_W-1:0] node_addr;
  logic [NODE_W-1:0] node_rd_data = '0;
  logic feat_rd_en;
  logic [FIDX_W-1:0] feat_addr;
  logic [DATA_W-1:0] feat_rd_data = '0;
  logic [DATA_W-1:0] cmp_din1, cmp_din2;
  logic [7:0] cmp_result;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [CLASS_W-1:0] out_class;
  logic out_err;

  tree_node_walker #(
    .DATA_W(DATA_W), .FIDX_W(FIDX_W), .ADDR_W(ADDR_W), .CLASS_W(CLASS_W),
    .CMP_LAT(CMP_LAT), .MAX_DEPTH(MAX_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready), .root_addr(root_addr),
    .node_rd_en(node_rd_en), .node_addr(node_addr), .node_rd_data(node_rd_data),
    .feat_rd_en(feat_rd_en), .feat_addr(feat_addr), .feat_rd_data(feat_rd_data),
    .cmp_din1(cmp_din1), .cmp_din2(cmp_din2), .cmp_result(cmp_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .out_err(out_err)
  );

  always #5 clk = ~clk;

  logic [NODE_W-1:0] node_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] feat_mem [0:(1<<FIDX_W)-1];
  logic cmp_p1 = 1'b0, cmp_p2 = 1'b0;
  logic [6:0] cmp_junk = '0;

  // Registered-read RAMs and a signed comparator with CMP_LAT=2 stages;
  // upper result bits carry noise the walker must ignore.
  always @(posedge clk) begin
    if (node_rd_en) node_rd_data <= node_mem[node_addr];
    if (feat_rd_en) feat_rd_data <= feat_mem[feat_addr];
    cmp_p1   <= ($signed(cmp_din1) <= $signed(cmp_din2));
    cmp_p2   <= cmp_p1;
    cmp_junk <= 7'($urandom);
  end
  assign cmp_result = {cmp_junk, cmp_p2};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NODE_W-1:0] mk(input logic leaf, input logic [7:0] f,
      input logic [23:0] thr, input logic [9:0] l, input logic [9:0] r);
    return {leaf, f, thr, l, r};
  endfunction

  // Reference walk: visited addresses, and per internal node the feature
  // index, feature value and threshold presented to the comparator.
  logic [ADDR_W-1:0] q_addr [$];
  logic [FIDX_W-1:0] q_fidx [$];
  logic [DATA_W-1:0] q_feat [$];
  logic [DATA_W-1:0] q_thr  [$];

  task automatic model_walk(input logic [ADDR_W-1:0] root, output logic [CLASS_W-1:0] cls,
      output logic err, output int d);
    logic [ADDR_W-1:0] a;
    logic [NODE_W-1:0] w;
    logic [DATA_W-1:0] fv;
    q_addr.delete(); q_fidx.delete(); q_feat.delete(); q_thr.delete();
    a = root; d = 0; cls = '0; err = 1'b0;
    forever begin
      w = node_mem[a];
      q_addr.push_back(a);
      if (w[52]) begin
        cls = w[27:20];
        return;
      end
      if (d == MAX_DEPTH) begin
        err = 1'b1;
        return;
      end
      fv = feat_mem[w[51:44]];
      q_fidx.push_back(w[51:44]);
      q_feat.push_back(fv);
      q_thr.push_back(w[43:20]);
      a = ($signed(fv) <= $signed(w[43:20])) ? w[19:10] : w[9:0];
      d++;
    end
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] root);
    @(negedge clk);
    check_eq("start_ready_idle", start_ready, 1'b1);
    start_valid = 1'b1;
    root_addr = root;
    @(posedge clk);
    #1 start_valid = 1'b0;
    root_addr = ADDR_W'($urandom);
  endtask

  task automatic run_walk(input logic [ADDR_W-1:0] root, input int hold);
    logic [CLASS_W-1:0] ecls;
    logic eerr;
    int ed, cyc, nfeat, k;
    bit done;
    model_walk(root, ecls, eerr, ed);
    do_start(root);
    cyc = 0; nfeat = 0; done = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      k = cyc / NODE_CYC;
      if (feat_rd_en) nfeat++;
      if (cyc % NODE_CYC == 0 && k <= ed)
        check_eq("node_rd", {node_rd_en, node_addr}, {1'b1, q_addr[k]});
      if (cyc % NODE_CYC == 1 && k < ed)
        check_eq("feat_rd", {feat_rd_en, feat_addr}, {1'b1, q_fidx[k]});
      if (cyc % NODE_CYC >= 3 && k < ed)
        check_eq("cmp_ops", {cmp_din1, cmp_din2}, {q_feat[k], q_thr[k]});
      if (out_valid) done = 1;
      else begin
        @(posedge clk);
        cyc++;
      end
    end
    check_eq("out_valid_seen", out_valid, 1'b1);
    check_eq("latency", cyc, 2 + NODE_CYC * ed);
    check_eq("result", {out_err, out_class}, {eerr, ecls});
    check_eq("feat_pulses", nfeat, ed);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1 start_valid = (i == hold / 2);
      root_addr = ADDR_W'($urandom);
      @(negedge clk);
      check_eq("hold", {out_valid, start_ready, out_err, out_class}, {2'b10, eerr, ecls});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    start_valid = 1'b0;
    @(negedge clk);
    check_eq("after_accept", {out_valid, start_ready, node_rd_en}, 3'b010);
    $display("walk root=%0d depth=%0d class=%0h err=%0d cycles=%0d hold=%0d",
             root, ed, out_class, out_err, cyc, hold);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) node_mem[i] = mk(1'b1, 8'd0, 24'd0, 10'd0, 10'd0);
    for (int i = 0; i < (1 << FIDX_W); i++) feat_mem[i] = 24'($urandom);

    #23;
    check_eq("reset_outs",
             {start_ready, node_rd_en, node_addr, feat_rd_en, feat_addr, out_valid, out_err, out_class},
             {1'b1, 1'b0, 10'd0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0});
    check_eq("reset_cmp", {cmp_din1, cmp_din2}, 48'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Leaf at root
    node_mem[5] = mk(1'b1, 8'd0, 24'h00002A, 10'd0, 10'd0);
    run_walk(10'd5, 3);

    // One internal node; equality goes left
    node_mem[0] = mk(1'b0, 8'd3, 24'd100, 10'd1, 10'd2);
    node_mem[1] = mk(1'b1, 8'd0, 24'd7, 10'd0, 10'd0);
    node_mem[2] = mk(1'b1, 8'd0, 24'd9, 10'd0, 10'd0);
    feat_mem[3] = 24'd100;
    run_walk(10'd0, 0);
    feat_mem[3] = 24'd101;
    run_walk(10'd0, 1);

    // Negative feature versus small positive threshold
    node_mem[0] = mk(1'b0, 8'd3, 24'h000005, 10'd1, 10'd2);
    feat_mem[3] = 24'hFFFFF6;
    run_walk(10'd0, 2);

    // Self-loop hits the depth limit; long backpressure at OUT
    node_mem[0] = mk(1'b0, 8'd4, 24'h123456, 10'd0, 10'd0);
    run_walk(10'd0, 10);

    // Reset in the middle of a depth-3 walk
    node_mem[0] = mk(1'b0, 8'd0, 24'h7FFFFF, 10'd1, 10'd1);
    node_mem[1] = mk(1'b0, 8'd0, 24'h7FFFFF, 10'd2, 10'd2);
    node_mem[2] = mk(1'b0, 8'd0, 24'h7FFFFF, 10'd3, 10'd3);
    node_mem[3] = mk(1'b1, 8'd0, 24'h000055, 10'd0, 10'd0);
    feat_mem[0] = 24'd0;
    do_start(10'd0);
    repeat (NODE_CYC + 3) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("async_reset_outs",
             {start_ready, node_rd_en, node_addr, feat_rd_en, feat_addr, out_valid, out_err, out_class},
             {1'b1, 1'b0, 10'd0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0});
    check_eq("async_reset_cmp", {cmp_din1, cmp_din2}, 48'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_reset", {start_ready, out_valid}, 2'b10);
    $display("reset mid-walk: start_ready=%0d out_valid=%0d", start_ready, out_valid);
    run_walk(10'd0, 1);

    // Random trees over a small address window; loops may hit the depth limit
    for (int t = 0; t < 25; t++) begin
      for (int a = 0; a < 32; a++)
        node_mem[a] = mk(($urandom_range(0, 9) < 4), 8'($urandom_range(0, 15)), 24'($urandom),
                         10'($urandom_range(0, 31)), 10'($urandom_range(0, 31)));
      for (int f = 0; f < 16; f++) feat_mem[f] = 24'($urandom);
      run_walk(10'($urandom_range(0, 31)), $urandom_range(0, 4));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
